// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: round-robin grant, iterative execute on one shared ALU,
// and a held response until the consumer accepts it.

module alu_sched_alu (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] sel,
    output logic [7:0] R
);

    // Modulo-256 arithmetic; carry and borrow are simply dropped.
    always_comb begin
        R = 8'h00;
        case (sel)
            3'b000:  R = A + B;
            3'b001:  R = A - B;
            3'b010:  R = A & B;
            3'b011:  R = A | B;
            3'b100:  R = {A[6:0], A[7]};
            3'b101:  R = {A[0], A[7:1]};
            default: R = 8'h00;
        endcase
    end

endmodule

module alu_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic [2:0] req0_cnt,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    input  logic [2:0] req1_cnt,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_acc;
    logic [7:0] r_b;
    logic [2:0] r_sel;
    logic [2:0] r_iter;
    logic       r_id;
    logic       r_last;
    logic       r_rst_d;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_can_grant;
    logic [7:0] w_alu_r;

    alu_sched_alu u_alu (
        .A   (r_acc),
        .B   (r_b),
        .sel (r_sel),
        .R   (w_alu_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are suppressed while reset is asserted and in the first cycle after it.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_can_grant = !rst && !r_rst_d;
        case (r_state)
            S_IDLE: begin
                if (w_can_grant) begin
                    if (req0_valid && (!req1_valid || r_last)) begin
                        w_grant0 = 1'b1;
                    end else if (req1_valid) begin
                        w_grant1 = 1'b1;
                    end
                    if (w_grant0 || w_grant1) begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (r_iter == 3'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_last starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= 8'h00;
            r_b     <= 8'h00;
            r_sel   <= 3'd0;
            r_iter  <= 3'd0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_rst_d <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            if (w_grant0) begin
                r_acc  <= req0_a;
                r_b    <= req0_b;
                r_sel  <= req0_sel;
                r_iter <= req0_cnt;
                r_id   <= 1'b0;
                r_last <= 1'b0;
            end else if (w_grant1) begin
                r_acc  <= req1_a;
                r_b    <= req1_b;
                r_sel  <= req1_sel;
                r_iter <= req1_cnt;
                r_id   <= 1'b1;
                r_last <= 1'b1;
            end else if (r_state == S_EXEC) begin
                r_acc <= w_alu_r;
                if (r_iter != 3'd0) begin
                    r_iter <= r_iter - 3'(1);
                end
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign rsp_data   = r_acc;
    assign rsp_id     = r_id;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: single-op vector table plus arbitration, hold and reset sequences.

module tb_alu_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req0_cnt, req1_sel, req1_cnt;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [2:0] cnt;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[12];

    alu_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req0_cnt   (req0_cnt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .req1_cnt   (req1_cnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel, input logic [2:0] cnt);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; req0_cnt = cnt;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; req1_cnt = cnt;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    // Single op; inputs scrambled after grant; checks grant, latency, data and id.
    task automatic do_op(input int idx, input vec_t v);
        int k;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(v.id, 1'b1, v.a, v.b, v.sel, v.cnt);
        #1;
        chk($sformatf("v%0d_ready", idx), 32'(v.id ? req1_ready : req0_ready), 32'd1);
        @(negedge clk);
        set_req(v.id, 1'b0, ~v.a, ~v.b, v.sel ^ 3'd1, ~v.cnt);
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(k), 32'(v.cnt) + 32'd2);
        chk($sformatf("v%0d_data", idx), 32'(rsp_data), 32'(v.exp));
        chk($sformatf("v%0d_id", idx), 32'(rsp_id), 32'(v.id));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_idle", idx), {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n, both, cyc, cnt_v;
        logic [7:0] exp_d;

        vt[0]  = '{1'b0, 8'h05, 8'h03, 3'b000, 3'd0, 8'h08};
        vt[1]  = '{1'b0, 8'hFF, 8'h01, 3'b000, 3'd0, 8'h00};
        vt[2]  = '{1'b1, 8'h00, 8'h01, 3'b001, 3'd0, 8'hFF};
        vt[3]  = '{1'b0, 8'h5A, 8'h33, 3'b110, 3'd0, 8'h00};
        vt[4]  = '{1'b1, 8'h81, 8'h00, 3'b100, 3'd3, 8'h18};
        vt[5]  = '{1'b0, 8'hF0, 8'h3C, 3'b010, 3'd1, 8'h30};
        vt[6]  = '{1'b1, 8'h01, 8'h80, 3'b011, 3'd0, 8'h81};
        vt[7]  = '{1'b0, 8'h01, 8'h00, 3'b101, 3'd2, 8'h20};
        vt[8]  = '{1'b1, 8'h10, 8'h10, 3'b000, 3'd7, 8'h90};
        vt[9]  = '{1'b1, 8'h05, 8'h02, 3'b001, 3'd2, 8'hFF};
        vt[10] = '{1'b0, 8'hFF, 8'h12, 3'b111, 3'd1, 8'h00};
        vt[11] = '{1'b0, 8'h80, 8'h00, 3'b100, 3'd0, 8'h01};

        // Reset with both requesters already valid; no grant in the reset or following cycle.
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'h01, 8'h01, 3'b000, 3'd0);
        set_req(1'b1, 1'b1, 8'h10, 8'h01, 3'b000, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_busy_valid", {30'd0, busy, rsp_valid}, 32'd0);
        chk("rst_data_id", {23'd0, rsp_id, rsp_data}, 32'd0);

        // Both valid continuously: round-robin 0,1,0,1.
        n = 0; both = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            if (req0_ready && req1_ready) both++;
            if (rsp_valid) begin
                exp_d = (n % 2 == 0) ? 8'h02 : 8'h11;
                chk($sformatf("rr%0d_id", n), 32'(rsp_id), 32'(n % 2));
                chk($sformatf("rr%0d_data", n), 32'(rsp_data), 32'(exp_d));
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_exclusive", 32'(both), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        for (int i = 0; i < 12; i++) do_op(i, vt[i]);

        // Response held for several cycles with both requesters waiting.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'h22, 8'h11, 3'b000, 3'd0);
        #1;
        chk("hold_grant0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        set_req(1'b1, 1'b1, 8'h44, 8'h01, 3'b000, 3'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_valid_busy", i), {30'd0, rsp_valid, busy}, 32'd3);
            chk($sformatf("hold%0d_data_id", i), {23'd0, rsp_id, rsp_data}, 32'h033);
            chk($sformatf("hold%0d_ready", i), {30'd0, req0_ready, req1_ready}, 32'd0);
            if (i == 2) rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        chk("hold_release_busy", 32'(busy), 32'd0);
        chk("hold_release_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_next_data_id", {23'd0, rsp_id, rsp_data}, 32'h145);
        drain();

        // Reset in the middle of a long operation aborts it.
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'h01, 8'h01, 3'b000, 3'd5);
        #1;
        chk("abort_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_after_rst", {29'd0, busy, rsp_valid, req0_ready | req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) cnt_v++;
        end
        chk("abort_no_rsp", 32'(cnt_v), 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 8'h07, 8'h02, 3'b001, 3'd0);
        set_req(1'b1, 1'b1, 8'h09, 8'h09, 3'b000, 3'd0);
        #1;
        chk("abort_tie_req0", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_next_data_id", {23'd0, rsp_id, rsp_data}, 32'h005);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
